// File: rtl/aes256_ctr_regs_pkg.sv
// Register map, response codes and address decode for the AES-256-CTR AXI4-Lite register file.
// Latency: n/a (constants and a combinational decode helper only).
// Backpressure: n/a.
package aes256_ctr_regs_pkg;

  // Byte offsets within the 64-byte register window
  localparam logic [5:0] CONTROL_ADDR    = 6'h00;
  localparam logic [5:0] STATUS_ADDR     = 6'h04;
  localparam logic [5:0] KEY_PART_0_ADDR = 6'h08;
  localparam logic [5:0] KEY_PART_7_ADDR = 6'h24;
  localparam logic [5:0] IV_PART_0_ADDR  = 6'h28;
  localparam logic [5:0] IV_PART_3_ADDR  = 6'h34;

  localparam int NUM_KEY_WORDS = 8;
  localparam int NUM_IV_WORDS  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_CONTROL,
    REG_STATUS,
    REG_KEY,
    REG_IV,
    REG_NONE
  } reg_kind_e;

  // Decoded target: register class plus word index inside the KEY/IV bank
  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] idx;
  } reg_sel_t;

  // Maps a word offset (address bits [5:2]) to a register; anything outside
  // the 64-byte window or past IV3 is unmapped.
  function automatic reg_sel_t decode_word(input logic in_window, input logic [3:0] word);
    reg_sel_t   sel;
    logic [2:0] rel_key;
    logic [1:0] rel_iv;
    sel.kind = REG_NONE;
    sel.idx  = '0;
    rel_key  = 3'(word - KEY_PART_0_ADDR[5:2]);
    rel_iv   = 2'(word - IV_PART_0_ADDR[5:2]);
    if (in_window) begin
      if (word == CONTROL_ADDR[5:2]) begin
        sel.kind = REG_CONTROL;
      end else if (word == STATUS_ADDR[5:2]) begin
        sel.kind = REG_STATUS;
      end else if (word >= KEY_PART_0_ADDR[5:2] && word <= KEY_PART_7_ADDR[5:2]) begin
        sel.kind = REG_KEY;
        sel.idx  = rel_key;
      end else if (word >= IV_PART_0_ADDR[5:2] && word <= IV_PART_3_ADDR[5:2]) begin
        sel.kind = REG_IV;
        sel.idx  = {1'b0, rel_iv};
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/aes256_ctr_axil_regs.sv
// AXI4-Lite register file holding control bit, 256-bit key and 128-bit IV for the AES-256-CTR core.
// Latency: write commits on the edge both AW and W are present, B one cycle later; R one cycle after AR.
// Backpressure: one outstanding write (AW/W readies low until B handshake); arready low while rvalid.
// Build option: define AES_REGS_KEY_READBACK_EN to make KEY0..KEY7 readable (otherwise they read as 0).
module aes256_ctr_axil_regs
  import aes256_ctr_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [31:0]           status_i,
  output logic                  load_key_and_iv_o,
  output logic [255:0]          key_o,
  output logic [127:0]          iv_o,
  output logic                  cfg_commit_o
);

  logic                  alive_q;
  logic                  aw_held_q;
  logic                  w_held_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ctrl_q;
  logic                  cfg_commit_q;
  logic [31:0]           key_q [NUM_KEY_WORDS];
  logic [31:0]           iv_q  [NUM_IV_WORDS];

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_in_window;
  logic                  rd_in_window;
  reg_sel_t              wr_sel;
  reg_sel_t              rd_sel;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  // Readies stay low until the first edge after reset release
  assign s_axi_awready = alive_q & ~aw_held_q;
  assign s_axi_wready  = alive_q & ~w_held_q;
  assign s_axi_arready = alive_q & ~rvalid_q;

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign ar_fire = s_axi_arvalid & s_axi_arready;

  // Second-arriving side passes straight through so the commit is not delayed a cycle
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
  assign commit  = (aw_held_q | aw_fire) & (w_held_q | w_fire) & ~bvalid_q;

  assign wr_in_window = (wr_addr >> 6) == '0;
  assign rd_in_window = (s_axi_araddr >> 6) == '0;
  assign wr_sel       = decode_word(wr_in_window, wr_addr[5:2]);
  assign rd_sel       = decode_word(rd_in_window, s_axi_araddr[5:2]);
  assign wr_ok        = (wr_sel.kind == REG_CONTROL) || (wr_sel.kind == REG_KEY) ||
                        (wr_sel.kind == REG_IV);

  assign s_axi_bvalid      = bvalid_q;
  assign s_axi_bresp       = bresp_q;
  assign s_axi_rvalid      = rvalid_q;
  assign s_axi_rresp       = rresp_q;
  assign s_axi_rdata       = rdata_q;
  assign load_key_and_iv_o = ctrl_q;
  assign cfg_commit_o      = cfg_commit_q;

  // Address bits [1:0] and status bit 0 are intentionally ignored
  logic unused_bits;
  assign unused_bits = &{1'b0, wr_addr[1:0], s_axi_araddr[1:0], status_i[0], rd_sel};

  // Flatten the word banks onto the core-facing buses, word n at [32n+31:32n]
  always_comb begin
    key_o = '0;
    iv_o  = '0;
    for (int n = 0; n < NUM_KEY_WORDS; n++) key_o[32*n +: 32] = key_q[n];
    for (int n = 0; n < NUM_IV_WORDS; n++)  iv_o[32*n +: 32]  = iv_q[n];
  end

  // Marks the end of reset so the readies rise one edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  // AW/W holding registers; released together on the B handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axi_wdata;
      end
      if (bvalid_q && s_axi_bready) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  // Write response: raised the cycle after commit, held until bready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Register bank update and the control 1->0 commit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= 1'b0;
      cfg_commit_q <= 1'b0;
      for (int i = 0; i < NUM_KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < NUM_IV_WORDS; i++)  iv_q[i]  <= '0;
    end else begin
      cfg_commit_q <= commit && (wr_sel.kind == REG_CONTROL) && ctrl_q && !wr_data[0];
      if (commit) begin
        case (wr_sel.kind)
          REG_CONTROL: ctrl_q <= wr_data[0];
          REG_KEY:     key_q[wr_sel.idx] <= wr_data;
          REG_IV:      iv_q[wr_sel.idx[1:0]] <= wr_data;
          default:     ;
        endcase
      end
    end
  end

  // Read mux over the pre-commit register state
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel.kind)
      REG_CONTROL: rd_data = {31'd0, ctrl_q};
      REG_STATUS:  rd_data = {status_i[31:1], ctrl_q};
`ifdef AES_REGS_KEY_READBACK_EN
      REG_KEY:     rd_data = key_q[rd_sel.idx];
`else
      REG_KEY:     rd_data = '0;
`endif
      REG_IV:      rd_data = iv_q[rd_sel.idx[1:0]];
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // Read response register: captured on AR handshake, held until rready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_data;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: doc/aes256_ctr_axil_regs.md
Name: aes256_ctr_axil_regs

Overview:
AXI4-Lite responder (slave) register file for the AES-256-CTR core. It terminates the configuration bus that software or the bench master drives. It holds the control bit, the 256-bit key and the 128-bit IV, and exposes a read-only status word. It sits inside aes256_ctr_mode_top between the s_axi_* ports and the key-expansion/counter logic.

Parameters:
ADDR_WIDTH, 12, AXI-Lite address width; only bits [5:2] decoded, bits [1:0] ignored.
DATA_WIDTH, 32, AXI-Lite data width; fixed, other values unsupported.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
s_axi_wdata/wvalid/wready  in/in/out  32/1/1  write data channel (no strobes; full-word writes)
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
status_i  in  32  live core status, bits [31:1] (bit 0 overridden)
load_key_and_iv_o  out  1  control bit 0; core holds/flushes while high
key_o  out  256  master key; word n at key_o[32n+31:32n]
iv_o  out  128  initial counter block; word n at iv_o[32n+31:32n]
cfg_commit_o  out  1  one-cycle pulse when load_key_and_iv falls 1->0

Behaviour:
- Map: 0x00 CONTROL RW (bit 0 only; others read 0). 0x04 STATUS RO = {status_i[31:1], load_key_and_iv_o}. 0x08..0x24 KEY0..KEY7 RW. 0x28..0x34 IV0..IV3 RW. 0x38..0x3C and above: unmapped.
- Reset: all registers 0; all ready/valid outputs 0 during reset; awready, wready and arready become 1 in the first cycle after release. bresp = rresp = 2'b00, rdata = 0, cfg_commit_o = 0.
- Write path: AW and W are accepted independently, in either order or in the same cycle. Each side is captured in a holding register. awready drops after AW capture and wready drops after W capture until the response completes.
- Commit occurs on the edge where both sides are held, using pass-through when the second arrives. bvalid rises the next cycle and holds until bready. Both readies return the cycle after the B handshake. One outstanding write maximum.
- Writes to STATUS or unmapped addresses: no state change, bresp = SLVERR (2'b10). Otherwise OKAY.
- Read path: arready = !rvalid. On AR handshake, rdata/rresp are registered and rvalid rises next cycle, held stable until rready. Unmapped read: rdata 0, SLVERR.
- Read-after-write in the same cycle returns the pre-commit value.
- cfg_commit_o pulses the cycle after a CONTROL commit with wdata[0]=0 while the bit was 1. Writing 0 over 0, or 1 over 1, gives no pulse.
- Key/IV writes update key_o/iv_o immediately, regardless of the control bit. The core samples them only on cfg_commit_o.
- Reset mid-transaction: all channels abandoned, valids drop asynchronously, no partial register update.

Optional Feature:
AES_REGS_KEY_READBACK_EN:
- Defined: KEY0..KEY7 read back their stored values.
- Undefined: KEY reads return 0 with OKAY (key is write-only, the production default). IV and CONTROL are always readable.

Decomposition:
- aes256_ctr_regs_pkg: register offset localparams (CONTROL_ADDR=0x00 … IV_PART_3_ADDR=0x34), RESP_OKAY/RESP_SLVERR constants, word-index decode function, NUM_KEY_WORDS=8, NUM_IV_WORDS=4.
- No sub-module is needed. Write-channel holding logic stays inline.

Test Plan:
- Reset, then read 0x04 with status_i=0x0000_0006 -> rdata 0x0000_0006, OKAY, rvalid exactly 1 cycle after AR handshake.
- Write 0x00=1; write KEY0..7 with NIST key 603DEB10…0914DFF4 (word 0 = 0x0914DFF4); write IV0..3 = FCFDFEFF..F0F1F2F3; write 0x00=0 -> key_o/iv_o match, single cfg_commit_o pulse, status bit 0 reads 0.
- Issue W 3 cycles before AW (addr 0x28, data 0xA5A5A5A5), with bready low for 4 cycles -> iv_o[31:0]=0xA5A5A5A5, bvalid held stable, no second write accepted meanwhile.
- Write 0x04 and 0x40 -> bresp 2'b10, registers unchanged. Read 0x40 -> rdata 0, rresp 2'b10.
- Read 0x08 after writing 0x12345678 -> 0x12345678 with AES_REGS_KEY_READBACK_EN defined, 0x00000000 OKAY without.
- Assert rst_n low while bvalid=1 and key loaded -> bvalid 0 immediately, key_o=0, first post-reset transaction completes normally.
